// File: rtl/digit_tracker.sv
// Passive OLED stream observer: finds pixels of a target colour, reports the
// per-frame bounding box, a found flag and horizontal motion direction.
module digit_tracker #(
    parameter int unsigned OLED_WIDTH    = 96,
    parameter int unsigned OLED_HEIGHT   = 64,
    parameter logic [15:0] TARGET_COLOUR = 16'h043F,
    parameter int unsigned MIN_PIXELS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        sample_valid,
    input  logic [12:0] pixel_index,
    input  logic [15:0] pixel_data,
    output logic [6:0]  box_x,
    output logic [6:0]  box_y,
    output logic [6:0]  box_w,
    output logic [6:0]  box_h,
    output logic        found,
    output logic [1:0]  dir,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int unsigned IDX_W = 13;
    localparam int unsigned CRD_W = 7;
    localparam int unsigned CNT_W = 13;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OLED_WIDTH * OLED_HEIGHT - 1);
    localparam logic [CRD_W-1:0] LAST_COL = CRD_W'(OLED_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);

    localparam logic [0:0] ST_WAIT_SYNC = 1'b0;
    localparam logic [0:0] ST_ACCUM     = 1'b1;

    localparam logic [1:0] DIR_STILL = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic [CRD_W-1:0] col_q, col_d, row_q, row_d;
    logic [CRD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [CRD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_found_q, prev_found_d;
    logic [CRD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic [CRD_W-1:0] box_w_q, box_w_d, box_h_q, box_h_d;
    logic             found_q, found_d;
    logic [1:0]       dir_q, dir_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;

    logic             take, clear, match, last;
    logic [CRD_W-1:0] cur_col, cur_row;
    logic [CRD_W-1:0] b_min_x, b_max_x, b_min_y, b_max_y;
    logic [CRD_W-1:0] n_min_x, n_max_x, n_min_y, n_max_y;
    logic [CNT_W-1:0] b_cnt, n_cnt;

    // Next-state, accumulator and frame-end output logic
    always_comb begin
        state_d      = state_q;
        exp_idx_d    = exp_idx_q;
        col_d        = col_q;
        row_d        = row_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;
        cnt_d        = cnt_q;
        prev_found_d = prev_found_q;
        box_x_d      = box_x_q;
        box_y_d      = box_y_q;
        box_w_d      = box_w_q;
        box_h_d      = box_h_q;
        found_d      = found_q;
        dir_d        = dir_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        take         = 1'b0;
        clear        = 1'b0;
        cur_col      = col_q;
        cur_row      = row_q;

        if (!en) begin
            state_d      = ST_WAIT_SYNC;
            clear        = 1'b1;
            prev_found_d = 1'b0;
        end else if (sample_valid) begin
            case (state_q)
                ST_WAIT_SYNC: begin
                    if (pixel_index == '0) begin
                        take    = 1'b1;
                        clear   = 1'b1;
                        cur_col = '0;
                        cur_row = '0;
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (pixel_index == exp_idx_q) begin
                        take = 1'b1;
                    end else begin
                        // Discontinuity: drop the frame; index 0 restarts at once
                        sync_err_d = 1'b1;
                        clear      = 1'b1;
                        if (pixel_index == '0) begin
                            take    = 1'b1;
                            cur_col = '0;
                            cur_row = '0;
                        end else begin
                            state_d = ST_WAIT_SYNC;
                        end
                    end
                end
                default: state_d = ST_WAIT_SYNC;
            endcase
        end

        b_min_x = clear ? {CRD_W{1'b1}} : min_x_q;
        b_max_x = clear ? '0 : max_x_q;
        b_min_y = clear ? {CRD_W{1'b1}} : min_y_q;
        b_max_y = clear ? '0 : max_y_q;
        b_cnt   = clear ? '0 : cnt_q;

        match   = take && (pixel_data == TARGET_COLOUR);
        n_min_x = (match && (cur_col < b_min_x)) ? cur_col : b_min_x;
        n_max_x = (match && (cur_col > b_max_x)) ? cur_col : b_max_x;
        n_min_y = (match && (cur_row < b_min_y)) ? cur_row : b_min_y;
        n_max_y = (match && (cur_row > b_max_y)) ? cur_row : b_max_y;
        n_cnt   = (match && (b_cnt != CNT_MAX)) ? b_cnt + CNT_W'(1) : b_cnt;
        last    = take && (pixel_index == LAST_IDX);

        if (last) begin
            frame_done_d = 1'b1;
            state_d      = ST_WAIT_SYNC;
            min_x_d      = {CRD_W{1'b1}};
            max_x_d      = '0;
            min_y_d      = {CRD_W{1'b1}};
            max_y_d      = '0;
            cnt_d        = '0;
            dir_d        = DIR_STILL;
            if (n_cnt >= MIN_CNT) begin
                found_d      = 1'b1;
                prev_found_d = 1'b1;
                box_x_d      = n_min_x;
                box_y_d      = n_min_y;
                box_w_d      = n_max_x - n_min_x + CRD_W'(1);
                box_h_d      = n_max_y - n_min_y + CRD_W'(1);
                if (prev_found_q) begin
                    if (n_min_x > box_x_q)      dir_d = DIR_RIGHT;
                    else if (n_min_x < box_x_q) dir_d = DIR_LEFT;
                end
            end else begin
                found_d      = 1'b0;
                prev_found_d = 1'b0;
            end
        end else begin
            min_x_d = n_min_x;
            max_x_d = n_max_x;
            min_y_d = n_min_y;
            max_y_d = n_max_y;
            cnt_d   = n_cnt;
            if (take) begin
                exp_idx_d = pixel_index + IDX_W'(1);
                if (cur_col == LAST_COL) begin
                    col_d = '0;
                    row_d = cur_row + CRD_W'(1);
                end else begin
                    col_d = cur_col + CRD_W'(1);
                    row_d = cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT_SYNC;
            exp_idx_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            min_x_q      <= {CRD_W{1'b1}};
            max_x_q      <= '0;
            min_y_q      <= {CRD_W{1'b1}};
            max_y_q      <= '0;
            cnt_q        <= '0;
            prev_found_q <= 1'b0;
            box_x_q      <= '0;
            box_y_q      <= '0;
            box_w_q      <= '0;
            box_h_q      <= '0;
            found_q      <= 1'b0;
            dir_q        <= DIR_STILL;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_idx_q    <= exp_idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
            cnt_q        <= cnt_d;
            prev_found_q <= prev_found_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            box_w_q      <= box_w_d;
            box_h_q      <= box_h_d;
            found_q      <= found_d;
            dir_q        <= dir_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign box_w      = box_w_q;
    assign box_h      = box_h_q;
    assign found      = found_q;
    assign dir        = dir_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_digit_tracker.sv
// Bench for digit_tracker: table of frames with expected reports, scoreboarded
// on frame_done, plus hand-written sync, reset and enable sequences.
`timescale 1ns/1ps
module tb_digit_tracker;

    localparam int W    = 96;
    localparam int H    = 64;
    localparam int NPIX = W * H;
    localparam logic [15:0] TGT = 16'h043F;

    typedef struct {
        int x0; int x1; int y0; int y1;
        bit gaps;
        bit e_found; bit e_found5;
        int bx; int by; int bw; int bh;
        int edir;
    } vec_t;

    typedef struct {
        logic       found;
        logic       found5;
        logic [6:0] bx, by, bw, bh;
        logic [1:0] dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, en, sample_valid;
    logic [12:0] pixel_index;
    logic [15:0] pixel_data;
    logic [6:0]  box_x, box_y, box_w, box_h;
    logic        found, frame_done, sync_err;
    logic [1:0]  dir;
    logic [6:0]  box_x5, box_y5, box_w5, box_h5;
    logic        found5, frame_done5, sync_err5;
    logic [1:0]  dir5;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sync   = 0;
    int n_done   = 0;
    exp_t exp_q[$];
    vec_t vt[11];

    digit_tracker dut (
        .clk(clk), .reset(reset), .en(en), .sample_valid(sample_valid),
        .pixel_index(pixel_index), .pixel_data(pixel_data),
        .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .found(found), .dir(dir), .frame_done(frame_done), .sync_err(sync_err)
    );

    digit_tracker #(.MIN_PIXELS(5)) dut5 (
        .clk(clk), .reset(reset), .en(en), .sample_valid(sample_valid),
        .pixel_index(pixel_index), .pixel_data(pixel_data),
        .box_x(box_x5), .box_y(box_y5), .box_w(box_w5), .box_h(box_h5),
        .found(found5), .dir(dir5), .frame_done(frame_done5), .sync_err(sync_err5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: every frame_done pops one expected report
    always @(negedge clk) begin
        exp_t e;
        if (sync_err) n_sync++;
        if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("frame_done without expected frame", 64'(frame_done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("found",  64'(found),  64'(e.found));
                check("box_x",  64'(box_x),  64'(e.bx));
                check("box_y",  64'(box_y),  64'(e.by));
                check("box_w",  64'(box_w),  64'(e.bw));
                check("box_h",  64'(box_h),  64'(e.bh));
                check("dir",    64'(dir),    64'(e.dir));
                check("min5 frame_done", 64'(frame_done5), 64'(1));
                check("min5 found",      64'(found5),      64'(e.found5));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One valid sample; idle cycles carry target colour and index 0 to prove valid gating
    task automatic send(input logic [12:0] idx, input logic [15:0] d);
        sample_valid = 1'b1;
        pixel_index  = idx;
        pixel_data   = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        pixel_index  = '0;
        pixel_data   = TGT;
    endtask

    task automatic partial(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) send(13'(i), TGT);
    endtask

    task automatic run_frame(input vec_t v);
        exp_t e;
        int x;
        int y;
        logic [15:0] d;
        for (int i = 0; i < NPIX; i++) begin
            x = i % W;
            y = i / W;
            if (x >= v.x0 && x <= v.x1 && y >= v.y0 && y <= v.y1) begin
                d = TGT;
            end else begin
                d = 16'($urandom);
                if (d == TGT) d = 16'h043E;
            end
            if (i == NPIX - 1) begin
                e.found  = v.e_found;
                e.found5 = v.e_found5;
                e.bx     = 7'(v.bx);
                e.by     = 7'(v.by);
                e.bw     = 7'(v.bw);
                e.bh     = 7'(v.bh);
                e.dir    = 2'(v.edir);
                exp_q.push_back(e);
            end
            send(13'(i), d);
            if (v.gaps && i != NPIX - 1) idle($urandom_range(0, 3));
        end
        @(negedge clk);
        check("frame_done one cycle after last index", 64'(frame_done), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " box"}, 64'({box_x, box_y, box_w, box_h}), 64'(0));
        check({tag, " found/dir"}, 64'({found, dir}), 64'(0));
        check({tag, " pulses"}, 64'({frame_done, sync_err}), 64'(0));
        check({tag, " min5 found"}, 64'(found5), 64'(0));
    endtask

    initial begin
        int s;
        int dn;
        vt[0]  = '{20, 35, 20, 43, 1'b0, 1'b1, 1'b1, 20, 20, 16, 24, 0};
        vt[1]  = '{21, 36, 20, 43, 1'b0, 1'b1, 1'b1, 21, 20, 16, 24, 1};
        vt[2]  = '{19, 34, 20, 43, 1'b0, 1'b1, 1'b1, 19, 20, 16, 24, 2};
        vt[3]  = '{19, 34, 20, 43, 1'b0, 1'b1, 1'b1, 19, 20, 16, 24, 0};
        vt[4]  = '{-1, -2, -1, -2, 1'b0, 1'b0, 1'b0, 19, 20, 16, 24, 0};
        vt[5]  = '{50, 51, 10, 11, 1'b0, 1'b1, 1'b0, 50, 10,  2,  2, 0};
        vt[6]  = '{95, 95, 63, 63, 1'b0, 1'b1, 1'b0, 95, 63,  1,  1, 1};
        vt[7]  = '{ 0, 95,  0, 63, 1'b0, 1'b1, 1'b1,  0,  0, 96, 64, 2};
        vt[8]  = '{20, 35, 20, 43, 1'b0, 1'b1, 1'b1, 20, 20, 16, 24, 1};
        vt[9]  = '{40, 47, 30, 39, 1'b0, 1'b1, 1'b1, 40, 30,  8, 10, 0};
        vt[10] = '{20, 35, 20, 43, 1'b1, 1'b1, 1'b1, 20, 20, 16, 24, 0};

        reset = 1'b0;
        en = 1'b1;
        sample_valid = 1'b0;
        pixel_index = '0;
        pixel_data = TGT;
        #2;
        check_zero("in reset");
        idle(3);
        reset = 1'b1;
        idle(2);
        check_zero("after reset release");

        for (int k = 0; k < 8; k++) run_frame(vt[k]);

        // Index jump, out-of-range index, and an index-0 restart mid-frame
        partial(0, 100);
        send(13'd102, TGT);
        @(negedge clk);
        check("sync_err on 100->102", 64'(sync_err), 64'(1));
        check("no frame_done on jump", 64'(frame_done), 64'(0));
        partial(0, 49);
        send(13'd7000, TGT);
        @(negedge clk);
        check("sync_err on index 7000", 64'(sync_err), 64'(1));
        partial(0, 9);
        s = n_sync;
        run_frame(vt[8]);
        check("sync_err count on index-0 restart", 64'(n_sync - s), 64'(1));

        // Asynchronous reset mid-frame, then a stale tail that must be ignored
        partial(0, 3000);
        reset = 1'b0;
        #2;
        check_zero("async reset mid-frame");
        idle(2);
        reset = 1'b1;
        s = n_sync;
        dn = n_done;
        partial(3001, 3100);
        idle(2);
        check("no sync_err on stale tail", 64'(n_sync - s), 64'(0));
        check("no frame_done on stale tail", 64'(n_done - dn), 64'(0));
        run_frame(vt[9]);

        // Enable drop mid-frame, then a gapped frame after re-enable
        partial(0, 2000);
        s = n_sync;
        dn = n_done;
        en = 1'b0;
        send(13'd2001, TGT);
        idle(3);
        en = 1'b1;
        partial(2002, 2050);
        idle(2);
        check("no sync_err around en drop", 64'(n_sync - s), 64'(0));
        check("no frame_done around en drop", 64'(n_done - dn), 64'(0));
        check("outputs held while disabled", 64'({found, box_x, box_y}), 64'({1'b1, 7'd40, 7'd30}));
        run_frame(vt[10]);

        idle(3);
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));
        check("total frame_done pulses", 64'(n_done), 64'(11));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/digit_tracker.md
Name: digit_tracker

Overview:
- Passive observer on the OLED pixel stream: watches each (pixel_index, pixel_data) sample the OLED driver fetches, finds pixels matching a target colour, and reports the bounding box of the drawn digit once per frame.
- Also reports the motion direction between consecutive frames.
- Sits beside the moving-digit renderers. It is the read side of their px/py -> pixel_data interface, used for on-board self-check and debug LEDs.

Parameters:
OLED_WIDTH, 96, pixels per row
OLED_HEIGHT, 64, rows per frame
TARGET_COLOUR, 16'h043F, RGB565 value counted as digit (blue)
MIN_PIXELS, 1, minimum matching pixels in a frame for found=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  tracking enable
sample_valid  in  1  pixel_index/pixel_data valid this cycle
pixel_index  in  13  linear index, row-major, 0..OLED_WIDTH*OLED_HEIGHT-1
pixel_data  in  16  RGB565 colour for pixel_index
box_x  out  7  left column of last found box
box_y  out  7  top row of last found box
box_w  out  7  width (max_x-min_x+1)
box_h  out  7  height (max_y-min_y+1)
found  out  1  last completed frame had >=MIN_PIXELS matches
dir  out  2  00 still/unknown, 01 moved right, 10 moved left, 11 unused
frame_done  out  1  one-cycle pulse when outputs update
sync_err  out  1  one-cycle pulse on stream discontinuity

Behaviour:
- Reset is asynchronous and active-low. While reset=0, every output is 0, state is WAIT_SYNC, and the accumulators are cleared.
- States:
  - WAIT_SYNC: ignore samples until sample_valid with pixel_index==0.
  - ACCUM: accumulate one sample per sample_valid.
- Column/row position comes from internal col/row counters, not division. On index 0, col=0 and row=0. On each accepted sample, col increments; col wraps to 0 at OLED_WIDTH-1 and row increments.
- Entering ACCUM: the index-0 sample is itself accumulated.
- Expected index in ACCUM is the previous accepted index +1.
  - If sample_valid and pixel_index != expected: the frame is discarded, sync_err pulses the next cycle, and outputs are unchanged.
  - If that index is 0, a new frame starts immediately in ACCUM. Otherwise the state goes to WAIT_SYNC.
- Match rule: pixel_data==TARGET_COLOUR, exact 16-bit compare. A match updates min_x, max_x, min_y, max_y (7-bit) and a 13-bit saturating count.
- Frame end: an accepted sample with index OLED_WIDTH*OLED_HEIGHT-1. One cycle later (latency 1):
  - frame_done=1 for one cycle.
  - If count>=MIN_PIXELS: found=1 and box_* are loaded from min/max.
  - Otherwise: found=0, box_* hold their previous values, and dir=00.
  - dir: if both this frame and the previous completed frame were found, compare new box_x to the previous box_x: greater gives 01, less gives 10, equal gives 00. Otherwise dir=00.
  - Accumulators clear; state goes to WAIT_SYNC, and the next index-0 sample restarts accumulation.
- Samples with pixel_index >= OLED_WIDTH*OLED_HEIGHT count as a discontinuity (sync_err).
- sample_valid=0 cycles are ignored. Gaps between samples are legal.
- en=0:
  - Any partial frame is abandoned, the state forces WAIT_SYNC, and outputs hold.
  - No frame_done or sync_err fires.
  - The "previous frame found" flag clears, so the first frame after re-enable gives dir=00.
- Reset mid-frame: all state clears asynchronously. The first frame after release that starts at index 0 is valid.
- Single-pixel match yields box_w=box_h=1. A full-screen match yields box_w=96, box_h=64.

Test Plan:
- Reset then one full frame, digit pixels at x=20..35, y=20..43 -> one cycle after index 6143: frame_done=1, found=1, box=(20,20,16,24), dir=00.
- Second frame with same digit at x=21..36 -> box_x=21, dir=01. Third frame at x=19 -> dir=10. Fourth frame at x=19 -> dir=00.
- All-black frame -> frame_done=1, found=0, box_* keep previous values, dir=00. MIN_PIXELS=5 with 4 matching pixels -> found=0.
- Index jumps 100->102 mid-frame -> sync_err pulse, no frame_done; next clean frame reports correctly. Index 7000 injected -> sync_err.
- Reset asserted at index 3000 -> all outputs 0 immediately. After release, a partial stream from index 3001 is ignored until index 0. The following full frame reports correctly.
- en dropped at index 2000 then raised -> no pulses. Next full frame gives found=1 with dir=00. Random sample_valid gaps of 0..3 cycles give the same box results as a dense stream.
